// File: rtl/regfile_dump_reader.sv
// Walks register-file indices FIRST_REG..NUM_REGS-1 and streams each word MSB-byte-first
// over a valid/ready byte channel. Define REGDUMP_HEADER_EN to prefix each word with its index.
module regfile_dump_reader #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rf_rd_addr_o,
    input  logic [DATA_W-1:0] rf_rd_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned BcntW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [BcntW-1:0] LastBcnt = BcntW'(NumBytes - 1);
    localparam logic [7:0]       FirstIdx = 8'(FIRST_REG);
    localparam logic [7:0]       LastIdx  = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
`ifdef REGDUMP_HEADER_EN
        StHdr,
`endif
        StSend,
        StDone
    } state_e;

    state_e              state_q;
    logic [7:0]          idx_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   shreg_shl;
    logic [BcntW-1:0]    bcnt_q;
    logic                busy_q;
    logic                done_q;
    logic                tx_valid_q;
    logic [7:0]          tx_data_q;
    logic [ADDR_W-1:0]   rf_rd_addr_q;

    // The next beat is pre-computed from the shifted word so tx_data stays a register.
    assign shreg_shl = shreg_q << 8;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            shreg_q      <= '0;
            bcnt_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            rf_rd_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        rf_rd_addr_q <= ADDR_W'(FirstIdx);
                        idx_q        <= FirstIdx;
                        busy_q       <= 1'b1;
                        state_q      <= StAddr;
                    end
                end
                StAddr: begin
                    shreg_q    <= rf_rd_data_i;
                    bcnt_q     <= '0;
                    tx_valid_q <= 1'b1;
`ifdef REGDUMP_HEADER_EN
                    tx_data_q  <= idx_q;
                    state_q    <= StHdr;
`else
                    tx_data_q  <= rf_rd_data_i[DATA_W-1 -: 8];
                    state_q    <= StSend;
`endif
                end
`ifdef REGDUMP_HEADER_EN
                StHdr: begin
                    if (tx_ready_i) begin
                        tx_data_q <= shreg_q[DATA_W-1 -: 8];
                        state_q   <= StSend;
                    end
                end
`endif
                StSend: begin
                    if (tx_ready_i) begin
                        if (bcnt_q != LastBcnt) begin
                            shreg_q   <= shreg_shl;
                            bcnt_q    <= bcnt_q + BcntW'(1);
                            tx_data_q <= shreg_shl[DATA_W-1 -: 8];
                        end else begin
                            tx_valid_q <= 1'b0;
                            if (idx_q == LastIdx) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                idx_q        <= idx_q + 8'd1;
                                rf_rd_addr_q <= ADDR_W'(idx_q + 8'd1);
                                state_q      <= StAddr;
                            end
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign tx_valid_o   = tx_valid_q;
    assign tx_data_o    = tx_data_q;
    assign rf_rd_addr_o = rf_rd_addr_q;

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the MIPS datapath register file. On a start pulse it walks register indices FIRST_REG..NUM_REGS-1 through the register file's read port, captures each word, and streams it out MSB-byte-first as 8-bit beats over a valid/ready byte channel. The byte channel feeds the board's debug serializer. This replaces ad-hoc simulation printing with observable hardware traffic.

## Interface
- DATA_W, 32, register word width; a multiple of 8.
- NUM_REGS, 32, number of register file entries; at most 256.
- FIRST_REG, 0, first index dumped; less than NUM_REGS.
- ADDR_W, 5, width of rf_rd_addr; 2^ADDR_W >= NUM_REGS.

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a dump; ignored while busy=1
- busy  out  1  high from the cycle after start is accepted until done falls
- done  out  1  one-cycle pulse after the last byte is accepted
- rf_rd_addr  out  ADDR_W  register-file read address; registered output
- rf_rd_data  in  DATA_W  register-file read data; the register file updates it on negedge clk
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts the beat when tx_valid=1 and tx_ready=1 at a posedge

## Operation
- The state register holds IDLE, ADDR, HDR, SEND or DONE.
- Internal state:
  - idx: register index counter.
  - shreg: DATA_W shift register.
  - bcnt: byte counter, 0..DATA_W/8-1.
- IDLE:
  - busy=0, tx_valid=0.
  - On start=1: rf_rd_addr<=FIRST_REG, idx<=FIRST_REG, go to ADDR.
- ADDR (exactly one cycle):
  - rf_rd_addr is stable. The register file drives rf_rd_data at the mid-cycle negedge.
  - At the closing posedge: shreg<=rf_rd_data, bcnt<=0.
  - Go to HDR if REGDUMP_HEADER_EN is defined, otherwise go to SEND.
- HDR:
  - tx_valid=1, tx_data=idx zero-extended to 8 bits.
  - On handshake, go to SEND.
- SEND:
  - tx_valid=1, tx_data=shreg[DATA_W-1:DATA_W-8].
  - On handshake with bcnt<DATA_W/8-1: shreg<=shreg<<8, bcnt<=bcnt+1.
  - On handshake with bcnt=DATA_W/8-1:
    - If idx=NUM_REGS-1, go to DONE.
    - Otherwise idx<=idx+1, rf_rd_addr<=idx+1, go to ADDR.
- DONE (one cycle):
  - done=1, tx_valid=0.
  - Go to IDLE.
- Handshake rules:
  - Once tx_valid rises, tx_valid and tx_data stay stable until the handshake.
  - tx_ready=0 stalls indefinitely with no loss or duplication.
  - tx_ready may be high before tx_valid; that is not a handshake.
- Arithmetic:
  - idx and rf_rd_addr never wrap past NUM_REGS-1.
  - Register contents are sent raw, with no byte swapping beyond MSB-first order.
- start while busy=1 (including the DONE cycle) is ignored and does not queue.
- start in the IDLE cycle immediately after DONE is accepted normally.
- The block never writes the register file and never touches the write port.

## Timing
- Reset: while reset=1, and immediately on assertion, all outputs are forced to their reset values:
  - busy=0, done=0, tx_valid=0.
  - tx_data=8'h00, rf_rd_addr=0.
  - State is IDLE, idx=0, bcnt=0, shreg=0.
- Reset asserted mid-dump aborts it: tx_valid drops asynchronously and no done pulse is generated.
- Latency with start at posedge E0:
  - ADDR occupies E0..E1.
  - The first tx_valid is visible after E1.
- Per-register cost with tx_ready held high:
  - 1 + DATA_W/8 cycles without the header.
  - 2 + DATA_W/8 cycles with the header.
- Full default dump (32 registers, DATA_W=32) with tx_ready=1:
  - 160 cycles plus the DONE cycle without the header.
  - 192 cycles plus the DONE cycle with the header.
- rf_rd_addr changes only on posedges. It holds its last value (NUM_REGS-1) after DONE.
- tx_data holds its last value when tx_valid=0.

## Configuration
- REGDUMP_HEADER_EN defined: each register is preceded by the HDR beat carrying its index. Each register occupies 1+DATA_W/8 beats.
- REGDUMP_HEADER_EN undefined:
  - The HDR state is not compiled.
  - ADDR goes directly to SEND.
  - The stream is pure data, DATA_W/8 beats per register.

## Test plan
- Reset state, data word, no header:
  - Stimulus: reset, preload reg0=0, reg1..31=1; start with tx_ready=1.
  - Required: bytes 00 00 00 00, then 00 00 00 01 repeated 31 times.
  - done pulses once, at cycle 161 after start.
- Known pattern: preload regN=32'hA5000000|N; start.
  - reg 7 appears as A5 00 00 07.
  - rf_rd_addr steps 0..31 exactly once.
- Backpressure:
  - Stimulus: tx_ready toggling with a pseudo-random pattern.
  - Required: the byte sequence is identical to the tx_ready=1 run.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
- start asserted during busy, and again in the DONE cycle:
  - Both are ignored.
  - start one cycle after DONE begins a fresh dump from FIRST_REG.
- Reset mid-dump:
  - Stimulus: reset asserted during the reg 10 SEND state.
  - Required: tx_valid=0 and busy=0 immediately, no done pulse.
  - A new start dumps from reg 0.
- With REGDUMP_HEADER_EN defined:
  - The stream is 00 d0 d1 d2 d3 01 ..., reg 31 is headed by 8'h1F.
  - The full dump takes 192 cycles.
